// File: rtl/univ_shift_reg_if.sv
// Control and data bundle for univ_shift_reg.
// The master drives the operation inputs. The slave is the shift register itself.
interface univ_shift_reg_if #(
    parameter int N_WIDTH = 8
);
    localparam int AW = $clog2(N_WIDTH + 1);

    logic               en;
    logic [2:0]         op;
    logic               start;
    logic [AW-1:0]      amt;
    logic [N_WIDTH-1:0] data_in;
    logic               serr;
    logic               serl;
    logic [N_WIDTH-1:0] data_out;
    logic               so;
    logic               busy;
    logic               done;

    modport master (
        output en, op, start, amt, data_in, serr, serl,
        input  data_out, so, busy, done
    );

    modport slave (
        input  en, op, start, amt, data_in, serr, serl,
        output data_out, so, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register. It supports single-cycle operations and a counted burst mode
// that repeats one latched shift or rotate up to N_WIDTH times.
module univ_shift_reg #(
    parameter int N_WIDTH = 8
) (
    input  logic              clk,
    input  logic              clear,
    univ_shift_reg_if.slave   bus
);
    localparam int AW = $clog2(N_WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [N_WIDTH-1:0] q, q_nxt;
    logic               so_q, so_nxt;
    logic [2:0]         op_lat;
    logic [AW-1:0]      cnt;
    logic [AW-1:0]      amt_eff;
    logic               launch;
    logic               exec;
    logic [2:0]         exec_op;

    function automatic logic is_shift(input logic [2:0] o);
        return (o == 3'd1) || (o == 3'd2) || ((o >= 3'd4) && (o <= 3'd6));
    endfunction

    assign amt_eff = (bus.amt > AW'(N_WIDTH)) ? AW'(N_WIDTH) : bus.amt;
    assign launch  = (state == IDLE) && bus.start && is_shift(bus.op) && (bus.amt != '0);

    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // cnt holds the operations still owed after the current edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (launch && (amt_eff > AW'(1))) ? BUSY : DONE;
            BUSY:    if (cnt == AW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == BUSY);
        bus.done = (state == DONE);
    end

    always_comb begin
        exec    = 1'b0;
        exec_op = 3'd0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    exec    = launch;
                    exec_op = bus.op;
                end else if (bus.en) begin
                    exec    = 1'b1;
                    exec_op = bus.op;
                end
            end
            BUSY: begin
                exec    = 1'b1;
                exec_op = op_lat;
            end
            default: ;
        endcase
    end

    always_comb begin
        q_nxt  = q;
        so_nxt = so_q;
        if (exec) begin
            case (exec_op)
                3'd1: begin q_nxt = {bus.serr, q[N_WIDTH-1:1]};     so_nxt = q[0];         end
                3'd2: begin q_nxt = {q[N_WIDTH-2:0], bus.serl};     so_nxt = q[N_WIDTH-1]; end
                3'd3: begin q_nxt = bus.data_in;                                            end
                3'd4: begin q_nxt = {q[0], q[N_WIDTH-1:1]};         so_nxt = q[0];         end
                3'd5: begin q_nxt = {q[N_WIDTH-2:0], q[N_WIDTH-1]}; so_nxt = q[N_WIDTH-1]; end
                3'd6: begin q_nxt = {q[N_WIDTH-1], q[N_WIDTH-1:1]}; so_nxt = q[0];         end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q      <= '0;
            so_q   <= 1'b0;
            op_lat <= 3'd0;
            cnt    <= '0;
        end else begin
            q    <= q_nxt;
            so_q <= so_nxt;
            if (launch) begin
                op_lat <= bus.op;
                cnt    <= amt_eff - AW'(1);
            end else if (state == BUSY) begin
                cnt <= cnt - AW'(1);
            end
        end
    end

    assign bus.data_out = q;
    assign bus.so       = so_q;
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter N_WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have derived localparam AW = $clog2(N_WIDTH+1), the width of the burst-count input.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port clear  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port en  input  1  single-cycle operation enable.
REQ-006 SHALL have port op  input  3  operation: 0 hold, 1 SR, 2 SL, 3 load, 4 RR, 5 RL, 6 ASR, 7 hold.
REQ-007 SHALL have port start  input  1  burst launch pulse.
REQ-008 SHALL have port amt  input  AW  burst shift count.
REQ-009 SHALL have port data_in  input  N_WIDTH  parallel load data.
REQ-010 SHALL have port serr  input  1  serial input entering the MSB on SR.
REQ-011 SHALL have port serl  input  1  serial input entering the LSB on SL.
REQ-012 SHALL have port data_out  output  N_WIDTH  register contents, driven directly from flops.
REQ-013 SHALL have port so  output  1  registered bit most recently shifted or rotated out.
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement the operations as: SR q={serr,q[N-1:1]}, SL q={q[N-2:0],serl}, RR q={q[0],q[N-1:1]}, RL q={q[N-2:0],q[N-1]}, ASR q={q[N-1],q[N-1:1]}, load q=data_in.
REQ-017 SHALL set so on every shift or rotate: q[0] for SR, RR and ASR; q[N-1] for SL and RL; so SHALL hold its value otherwise.
REQ-018 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-019 IDLE, start=0, en=1: SHALL execute op in one cycle, with the result visible on data_out the cycle after the edge.
REQ-020 IDLE, en=0 and start=0: SHALL hold data_out.
REQ-021 IDLE, start=1, op a shift class (1, 2, 4, 5 or 6), amt>=1: SHALL latch op and min(amt,N_WIDTH) into an internal counter, perform the first operation on the same edge, and enter BUSY if more operations remain, otherwise DONE.
REQ-022 start SHALL take priority over en when both are asserted.
REQ-023 IDLE, start=1 with amt=0 or a non-shift op: SHALL leave data unchanged and go to DONE, giving a done pulse with no shifting.
REQ-024 BUSY: SHALL execute the latched op once per cycle, sampling serr/serl live each cycle, and decrement the counter.
REQ-025 BUSY: SHALL transition to DONE on the edge that performs the final operation.
REQ-026 BUSY: SHALL ignore en, op, start, amt and data_in.
REQ-027 DONE: SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-028 DONE: SHALL ignore start, so a new burst is accepted no earlier than the following IDLE cycle.
REQ-029 busy SHALL be 1 exactly while in BUSY.
REQ-030 A burst of amt=k SHALL occupy k edges of data change, with done high the cycle after the last change.
REQ-031 A burst with amt>N_WIDTH SHALL be clamped to N_WIDTH operations.
REQ-032 An RR or RL burst of N_WIDTH operations SHALL restore the original data_out.

Reset
REQ-033 clear=1 at a rising edge SHALL set data_out=0, so=0, busy=0, done=0, counter=0 and state=IDLE.
REQ-034 clear SHALL take priority over every other input.
REQ-035 clear during BUSY SHALL abort the burst with no done pulse.
REQ-036 The first operation after clear is deasserted SHALL be accepted on the next rising edge.

Verification (N_WIDTH=8)
REQ-037 Load then single ops: op=3, data_in=8'hA5, en=1 -> data_out=A5; op=1, serr=1 -> D2, so=1; op=6 -> E9, so=0.
REQ-038 Rotate burst: data_out=8'h81, op=4, start with amt=3 -> busy high for 2 cycles, data_out sequence C0, 60, 30, done pulse follows, so=0.
REQ-039 Clamp and identity: data_out=5A, op=5, amt=15 (clamped to 8) -> 8 shifts, final data_out=5A, then one done pulse.
REQ-040 Zero-count burst: start with amt=0 -> data unchanged, busy stays 0, done=1 the next cycle only.
REQ-041 Mid-burst abort: SL burst amt=6 with clear raised on the third cycle -> all outputs 0, IDLE, no done; en=1 with op=3 on the next cycle loads normally.
REQ-042 Inputs ignored during burst: toggle start, en, op and data_in randomly during BUSY -> burst result matches the reference model and no second burst starts until after done.
